// File: rtl/pe_frame_sched_pkg.sv
// Shared types and constants for the frame scheduler: FSM state encoding,
// default image geometry and the reset value of the latched opcode.
package pe_frame_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int DEF_IMG_W = 320;
    localparam int DEF_IMG_H = 240;

    localparam logic [2:0] FUNC_RST = 3'h7;

endpackage

// File: rtl/pe_frame_delay.sv
// Fixed-latency, non-stalling valid/address delay line that aligns the
// window-center address with the processed pixel leaving the PE.
module pe_frame_delay #(
    parameter int LAT    = 2,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_vld,
    input  logic [ADDR_W-1:0] src_addr,
    output logic              dly_vld,
    output logic [ADDR_W-1:0] dly_addr
);

    logic              vld_p  [LAT];
    logic [ADDR_W-1:0] addr_p [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                vld_p[i]  <= 1'b0;
                addr_p[i] <= '0;
            end
        end else begin
            vld_p[0]  <= src_vld;
            addr_p[0] <= src_addr;
            for (int i = 1; i < LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                addr_p[i] <= addr_p[i-1];
            end
        end
    end

    assign dly_vld  = vld_p[LAT-1];
    assign dly_addr = addr_p[LAT-1];

endmodule

// File: rtl/pe_frame_sched.sv
// Frame scheduler: walks a step counter over the image, issues source reads and
// delayed write-backs for a 3x3 PE. Optional busy-cycle counter: PE_FRAME_SCHED_PERF_EN.
module pe_frame_sched
    import pe_frame_sched_pkg::*;
#(
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int ADDR_W   = 17,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        func,
    input  logic              gray,
    input  logic              pause,
    output logic              busy,
    output logic [2:0]        func_lat,
    output logic              gray_lat,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              cnt_start,
    output logic              done,
    output logic [31:0]       perf_cycles
);

    localparam int N  = IMG_W * IMG_H;
    localparam int SW = ADDR_W + 1;

    state_t            state;
    logic [SW-1:0]     s;
    logic              scan;
    logic              ctr_vld;
    logic [ADDR_W-1:0] ctr_addr;

    assign scan     = (state == PRIME) || (state == RUN) || (state == FLUSH);
    assign rd_en    = scan && !pause && (s < SW'(N));
    assign rd_addr  = rd_en ? s[ADDR_W-1:0] : '0;
    // The center trails the read pointer by one row plus one pixel.
    assign ctr_vld  = ((state == RUN) || (state == FLUSH)) && !pause;
    assign ctr_addr = ctr_vld ? (s[ADDR_W-1:0] - ADDR_W'(IMG_W + 1)) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            s        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            func_lat <= FUNC_RST;
            gray_lat <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= PRIME;
                        s        <= '0;
                        busy     <= 1'b1;
                        func_lat <= func;
                        gray_lat <= gray;
                    end
                end
                PRIME: begin
                    if (!pause) begin
                        s <= s + 1'b1;
                        if (s == SW'(IMG_W)) state <= RUN;
                    end
                end
                RUN: begin
                    if (!pause) begin
                        s <= s + 1'b1;
                        if (s == SW'(N - 1)) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!pause) begin
                        if (s == SW'(N + IMG_W)) begin
                            state <= DRAIN;
                            s     <= '0;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                // s is reused to count out the pipeline latency; pause is ignored here.
                DRAIN: begin
                    if (s == SW'(PIPE_LAT - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        s <= s + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    s     <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    pe_frame_delay #(
        .LAT    (PIPE_LAT),
        .ADDR_W (ADDR_W)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .src_vld  (ctr_vld),
        .src_addr (ctr_addr),
        .dly_vld  (wr_valid),
        .dly_addr (wr_addr)
    );

    // Addresses are unique within a job, so address 0 marks the first write.
    assign cnt_start = wr_valid && (wr_addr == '0);

`ifdef PE_FRAME_SCHED_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if ((state == IDLE) && start) begin
            perf_q <= '0;
        end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_pe_frame_sched.sv
// Directed bench for pe_frame_sched with a 4x3 image and two-cycle pipeline.
module tb_pe_frame_sched;

    localparam int ADDR_W = 17;

    logic              clk;
    logic              rst;
    logic              start;
    logic [2:0]        func;
    logic              gray;
    logic              pause;
    logic              busy;
    logic [2:0]        func_lat;
    logic              gray_lat;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic              cnt_start;
    logic              done;
    logic [31:0]       perf_cycles;

    pe_frame_sched #(
        .IMG_W    (4),
        .IMG_H    (3),
        .ADDR_W   (ADDR_W),
        .PIPE_LAT (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .func        (func),
        .gray        (gray),
        .pause       (pause),
        .busy        (busy),
        .func_lat    (func_lat),
        .gray_lat    (gray_lat),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .cnt_start   (cnt_start),
        .done        (done),
        .perf_cycles (perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    int   first_wr, last_wr, wr_cnt, rd_cnt, done_cyc, done_cnt, cs_cyc, cs_cnt, busy_end;
    logic busy1;
    logic [2:0] flat_mid;
    logic wv [0:40];

    // Cycle j of a job is the interval following the j-th edge after acceptance.
    task automatic run_job(input logic [2:0] fn, input logic gr, input int p0, input int plen,
                           input int rs_j, input int rst_j, input int ncyc);
        int exp_rd;
        int exp_wr;
        exp_rd = 0; exp_wr = 0;
        first_wr = -1; last_wr = -1; wr_cnt = 0; rd_cnt = 0;
        done_cyc = -1; done_cnt = 0; cs_cyc = -1; cs_cnt = 0; busy_end = -1;
        busy1 = 1'b0; flat_mid = 3'd0;
        for (int i = 0; i <= 40; i++) wv[i] = 1'b0;
        @(negedge clk);
        func = fn; gray = gr; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 1; j <= ncyc; j++) begin
            pause = (j >= p0) && (j < p0 + plen);
            start = (j == rs_j);
            if (j == rs_j) func = 3'b001;
            rst = (j == rst_j);
            @(negedge clk);
            if (rd_en) begin
                check("rd_addr", 32'(rd_addr), exp_rd);
                exp_rd++; rd_cnt++;
            end
            if (wr_valid) begin
                check("wr_addr", 32'(wr_addr), exp_wr);
                exp_wr++; wr_cnt++;
                if (first_wr < 0) first_wr = j;
                last_wr = j;
            end
            wv[j] = wr_valid;
            if (cnt_start) begin cs_cnt++; cs_cyc = j; end
            if (done) begin done_cnt++; done_cyc = j; end
            if (!busy && busy_end < 0) busy_end = j;
            if (j == 1) busy1 = busy;
            if (j == 10) flat_mid = func_lat;
            if (j == rst_j) begin
                check("rst_busy", 32'(busy), 0);
                check("rst_rd_en", 32'(rd_en), 0);
                check("rst_wr_valid", 32'(wr_valid), 0);
                check("rst_wr_addr", 32'(wr_addr), 0);
                check("rst_done", 32'(done), 0);
                check("rst_func_lat", 32'(func_lat), 7);
                check("rst_gray_lat", 32'(gray_lat), 0);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0; pause = 1'b0; rst = 1'b0;
    endtask

    task automatic check_normal(input string tag);
        check({tag, "_busy1"}, 32'(busy1), 1);
        check({tag, "_rd_cnt"}, rd_cnt, 12);
        check({tag, "_wr_cnt"}, wr_cnt, 12);
        check({tag, "_first_wr"}, first_wr, 8);
        check({tag, "_last_wr"}, last_wr, 19);
        check({tag, "_cs_cyc"}, cs_cyc, 8);
        check({tag, "_cs_cnt"}, cs_cnt, 1);
        check({tag, "_done_cyc"}, done_cyc, 20);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_end"}, busy_end, 21);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; func = 3'd0; gray = 1'b0; pause = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_rd_en", 32'(rd_en), 0);
        check("reset_wr_valid", 32'(wr_valid), 0);
        check("reset_cnt_start", 32'(cnt_start), 0);
        check("reset_func_lat", 32'(func_lat), 7);
        check("reset_gray_lat", 32'(gray_lat), 0);
        check("reset_perf", perf_cycles, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Plain job, no pause.
        run_job(3'b010, 1'b1, 0, 0, 0, 0, 25);
        check_normal("A");
        check("A_func_lat", 32'(flat_mid), 2);
        check("A_gray_lat", 32'(gray_lat), 1);
`ifdef PE_FRAME_SCHED_PERF_EN
        check("A_perf", perf_cycles, 20);
`else
        check("A_perf", perf_cycles, 0);
`endif

        // Three paused cycles in RUN (s frozen at 6).
        run_job(3'b011, 1'b0, 7, 3, 0, 0, 28);
        check("B_rd_cnt", rd_cnt, 12);
        check("B_wr_cnt", wr_cnt, 12);
        check("B_first_wr", first_wr, 8);
        check("B_gap9", 32'(wv[9]), 0);
        check("B_gap10", 32'(wv[10]), 0);
        check("B_gap11", 32'(wv[11]), 0);
        check("B_resume12", 32'(wv[12]), 1);
        check("B_last_wr", last_wr, 22);
        check("B_done_cyc", done_cyc, 23);
        check("B_done_cnt", done_cnt, 1);

        // Start re-pulsed mid-job with a different opcode.
        run_job(3'b100, 1'b0, 0, 0, 5, 0, 25);
        check_normal("C");
        check("C_func_mid", 32'(flat_mid), 4);
        check("C_func_end", 32'(func_lat), 4);

        // Pause through DRAIN/DONE/IDLE has no effect.
        run_job(3'b101, 1'b1, 18, 4, 0, 0, 25);
        check_normal("D");

        // Abort at cycle 10, then a full job.
        run_job(3'b110, 1'b1, 0, 0, 0, 10, 15);
        check("E_done_cnt", done_cnt, 0);
        check("E_busy_end", busy_end, 10);
        check("E_cs_cnt", cs_cnt, 1);
        run_job(3'b001, 1'b0, 0, 0, 0, 0, 25);
        check_normal("F");
        check("F_func_lat", 32'(func_lat), 1);
`ifdef PE_FRAME_SCHED_PERF_EN
        check("F_perf", perf_cycles, 20);
`else
        check("F_perf", perf_cycles, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
